// File: rtl/matmul_pkg.sv
// Shared types and helpers for the fixed-point matrix multiplier.
// Holds the FSM state encoding and the result saturation function.
package matmul_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_COMPUTE,
    ST_EMIT,
    ST_DONE
  } state_t;

  // Arithmetic right shift by frac, then clamp to a signed width range.
  function automatic logic signed [63:0] sat_shift(
    input logic signed [63:0] acc,
    input int                 frac,
    input int                 width
  );
    logic signed [63:0] sh;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sh = acc >>> frac;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (sh > hi) begin
      return hi;
    end
    if (sh < lo) begin
      return lo;
    end
    return sh;
  endfunction

endpackage

// File: rtl/top_matmul_mac_lane.sv
// One output-column MAC lane: CHUNK_SIZE signed products per cycle
// summed into a wide accumulator that restarts on clr.
module matmul_mac_lane
  import matmul_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int CHUNK_SIZE = 4,
  parameter int ACC_WIDTH  = 35
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic                        clr,
  input  logic [WIDTH*CHUNK_SIZE-1:0] a,
  input  logic [WIDTH*CHUNK_SIZE-1:0] b,
  output logic signed [ACC_WIDTH-1:0] acc
);

  logic signed [ACC_WIDTH-1:0] sum;

  // Sum of the chunk's element products at full precision.
  always_comb begin
    logic signed [WIDTH-1:0]   ae;
    logic signed [WIDTH-1:0]   be;
    logic signed [2*WIDTH-1:0] p;
    sum = '0;
    ae  = '0;
    be  = '0;
    p   = '0;
    for (int m = 0; m < CHUNK_SIZE; m++) begin
      ae  = a[m*WIDTH +: WIDTH];
      be  = b[m*WIDTH +: WIDTH];
      p   = ae * be;
      sum = sum + ACC_WIDTH'(p);
    end
  end

  // Accumulator: first chunk of a row loads, later chunks add.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (en) begin
      acc <= clr ? sum : acc + sum;
    end
  end

endmodule

// File: rtl/top_matmul.sv
// Buffered fixed-point matrix multiply C = I x W, one C row per beat.
// Loads W and I row by row, then computes and emits each C row.
module top_matmul
  import matmul_pkg::*;
#(
  parameter int WIDTH             = 16,
  parameter int FRAC_WIDTH        = 8,
  parameter int BLOCK_SIZE        = 2,
  parameter int CHUNK_SIZE        = 4,
  parameter int I_OUTER_DIMENSION = 12,
  parameter int W_OUTER_DIMENSION = 6,
  parameter int INNER_DIMENSION   = 8
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 en_top_matmul,
  input  logic                                 input_i_valid,
  input  logic [WIDTH*INNER_DIMENSION-1:0]     input_i,
  input  logic                                 input_w_valid,
  input  logic [WIDTH*W_OUTER_DIMENSION-1:0]   input_w,
  output logic [WIDTH*W_OUTER_DIMENSION-1:0]   out_matmul_data,
  output logic                                 out_matmul_ready,
  output logic                                 out_matmul_last,
  output logic                                 out_matmul_done
);

  localparam int ACC_W  = 2*WIDTH + $clog2(INNER_DIMENSION);
  localparam int N_CH   = INNER_DIMENSION / CHUNK_SIZE;
  localparam int KW     = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int WAW    = $clog2(INNER_DIMENSION);
  localparam int WCW    = $clog2(INNER_DIMENSION + 1);
  localparam int IAW    = $clog2(I_OUTER_DIMENSION);
  localparam int ICW    = $clog2(I_OUTER_DIMENSION + 1);
  localparam int ROW_W  = WIDTH * W_OUTER_DIMENSION;
  localparam int IROW_W = WIDTH * INNER_DIMENSION;
  localparam int LANE_W = WIDTH * CHUNK_SIZE;

  if ((I_OUTER_DIMENSION % BLOCK_SIZE) != 0 ||
      (W_OUTER_DIMENSION % BLOCK_SIZE) != 0 ||
      (INNER_DIMENSION % CHUNK_SIZE) != 0) begin : g_bad_cfg
    $error("top_matmul: invalid tiling parameters");
  end

  state_t state;
  state_t state_n;

  logic [ROW_W-1:0]  w_mem [INNER_DIMENSION];
  logic [IROW_W-1:0] i_mem [I_OUTER_DIMENSION];

  logic [WCW-1:0] w_cnt;
  logic [ICW-1:0] i_cnt;
  logic [IAW-1:0] row;
  logic [KW-1:0]  chunk;

  logic w_full;
  logic i_full;
  logic loading;
  logic take_w;
  logic take_i;
  logic mac_en;
  logic emit;
  logic last_chunk;
  logic last_row;

  logic [LANE_W-1:0] lane_a;
  logic [LANE_W-1:0] lane_b [W_OUTER_DIMENSION];
  logic signed [ACC_W-1:0] acc [W_OUTER_DIMENSION];
  logic [ROW_W-1:0] row_res;

  assign w_full     = (w_cnt == WCW'(INNER_DIMENSION));
  assign i_full     = (i_cnt == ICW'(I_OUTER_DIMENSION));
  assign loading    = en_top_matmul &&
                      (state == ST_IDLE || state == ST_LOAD);
  assign take_w     = loading && input_w_valid && !w_full;
  assign take_i     = loading && input_i_valid && !i_full;
  assign mac_en     = en_top_matmul && (state == ST_COMPUTE);
  assign emit       = en_top_matmul && (state == ST_EMIT);
  assign last_chunk = (chunk == KW'(N_CH - 1));
  assign last_row   = (row == IAW'(I_OUTER_DIMENSION - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next state; a low enable freezes every working state.
  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE: begin
        if (en_top_matmul) state_n = ST_LOAD;
      end
      ST_LOAD: begin
        if (en_top_matmul && w_full && i_full) state_n = ST_COMPUTE;
      end
      ST_COMPUTE: begin
        if (mac_en && last_chunk) state_n = ST_EMIT;
      end
      ST_EMIT: begin
        if (emit) state_n = last_row ? ST_DONE : ST_COMPUTE;
      end
      ST_DONE: begin
        if (!en_top_matmul) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Load, chunk and row counters; cleared when the job is released.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_cnt <= '0;
      i_cnt <= '0;
      row   <= '0;
      chunk <= '0;
    end else begin
      if (take_w) w_cnt <= w_cnt + WCW'(1);
      if (take_i) i_cnt <= i_cnt + ICW'(1);
      if (mac_en) chunk <= last_chunk ? '0 : chunk + KW'(1);
      if (emit)   row   <= last_row ? '0 : row + IAW'(1);
      if (state == ST_DONE && !en_top_matmul) begin
        w_cnt <= '0;
        i_cnt <= '0;
        row   <= '0;
        chunk <= '0;
      end
    end
  end

  // Operand buffers; contents are only meaningful under the counters.
  always_ff @(posedge clk) begin
    if (take_w) w_mem[w_cnt[WAW-1:0]] <= input_w;
    if (take_i) i_mem[i_cnt[IAW-1:0]] <= input_i;
  end

  // Select the current chunk of I row and of each W column.
  always_comb begin
    int idx;
    idx    = 0;
    lane_a = '0;
    for (int j = 0; j < W_OUTER_DIMENSION; j++) lane_b[j] = '0;
    for (int m = 0; m < CHUNK_SIZE; m++) begin
      idx = int'(chunk) * CHUNK_SIZE + m;
      lane_a[m*WIDTH +: WIDTH] = i_mem[row][idx*WIDTH +: WIDTH];
      for (int j = 0; j < W_OUTER_DIMENSION; j++) begin
        lane_b[j][m*WIDTH +: WIDTH] =
          w_mem[WAW'(idx)][j*WIDTH +: WIDTH];
      end
    end
  end

  for (genvar j = 0; j < W_OUTER_DIMENSION; j++) begin : g_lane
    matmul_mac_lane #(
      .WIDTH      (WIDTH),
      .CHUNK_SIZE (CHUNK_SIZE),
      .ACC_WIDTH  (ACC_W)
    ) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (mac_en),
      .clr   (chunk == '0),
      .a     (lane_a),
      .b     (lane_b[j]),
      .acc   (acc[j])
    );
  end

  // Scale each accumulator back to element format with saturation.
  always_comb begin
    row_res = '0;
    for (int j = 0; j < W_OUTER_DIMENSION; j++) begin
      row_res[j*WIDTH +: WIDTH] =
        WIDTH'(sat_shift(64'(acc[j]), FRAC_WIDTH, WIDTH));
    end
  end

  // Registered result port: one ready beat per EMIT cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_matmul_data  <= '0;
      out_matmul_ready <= 1'b0;
      out_matmul_last  <= 1'b0;
      out_matmul_done  <= 1'b0;
    end else begin
      out_matmul_ready <= emit;
      out_matmul_last  <= emit && last_row;
      out_matmul_done  <= en_top_matmul && (state == ST_DONE);
      if (emit) out_matmul_data <= row_res;
    end
  end

endmodule

// File: tb/tb_top_matmul.sv
// Scoreboard bench for top_matmul against an integer reference model.
// Directed and random jobs, plus freeze and mid-job reset scenarios.
module tb_top_matmul;

  localparam int W  = 16;
  localparam int NI = 12;
  localparam int NW = 6;
  localparam int NK = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            en;
  logic            i_valid;
  logic [W*NK-1:0] i_data;
  logic            w_valid;
  logic [W*NW-1:0] w_data;
  logic [W*NW-1:0] o_data;
  logic            o_ready;
  logic            o_last;
  logic            o_done;

  top_matmul #(
    .WIDTH             (W),
    .FRAC_WIDTH        (8),
    .BLOCK_SIZE        (2),
    .CHUNK_SIZE        (4),
    .I_OUTER_DIMENSION (NI),
    .W_OUTER_DIMENSION (NW),
    .INNER_DIMENSION   (NK)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .en_top_matmul    (en),
    .input_i_valid    (i_valid),
    .input_i          (i_data),
    .input_w_valid    (w_valid),
    .input_w          (w_data),
    .out_matmul_data  (o_data),
    .out_matmul_ready (o_ready),
    .out_matmul_last  (o_last),
    .out_matmul_done  (o_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [W*NW-1:0] data;
    logic            last;
  } exp_t;

  exp_t exp_q[$];
  int   rdy_cyc[$];
  exp_t mon_e;

  logic signed [W-1:0] im [NI][NK];
  logic signed [W-1:0] wm [NK][NW];

  task automatic chk(string name, logic [127:0] act,
                     logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every ready beat must match the head of the scoreboard.
  always @(negedge clk) begin
    if (o_ready === 1'b1) begin
      rdy_cyc.push_back(cyc);
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_beat actual=%0h required=none",
                 o_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (o_data !== mon_e.data || o_last !== mon_e.last) begin
          failures++;
          $display("FAIL row_beat actual=%0h/%b required=%0h/%b",
                   o_data, o_last, mon_e.data, mon_e.last);
        end
      end
    end
  end

  // Reference: exact integer dot products, floor shift, clamp.
  function automatic logic [W*NW-1:0] model_row(int r);
    logic [W*NW-1:0] v;
    longint s;
    v = '0;
    for (int j = 0; j < NW; j++) begin
      s = 0;
      for (int k = 0; k < NK; k++)
        s += longint'(im[r][k]) * longint'(wm[k][j]);
      s = s >>> 8;
      if (s > 32767) s = 32767;
      else if (s < -32768) s = -32768;
      v[j*W +: W] = s[15:0];
    end
    return v;
  endfunction

  function automatic logic [W*NW-1:0] pack_w(int k);
    logic [W*NW-1:0] v;
    for (int j = 0; j < NW; j++) v[j*W +: W] = wm[k][j];
    return v;
  endfunction

  function automatic logic [W*NK-1:0] pack_i(int r);
    logic [W*NK-1:0] v;
    for (int k = 0; k < NK; k++) v[k*W +: W] = im[r][k];
    return v;
  endfunction

  function automatic logic signed [W-1:0] rnd_el();
    int t;
    if ($urandom_range(0, 1) == 1) return W'($urandom);
    t = int'($urandom_range(0, 2048)) - 1024;
    return W'(t);
  endfunction

  // 0 ones, 1 identity, 2 all 127.0, 3 single -1.0, 4 random.
  task automatic fill(int mode);
    for (int r = 0; r < NI; r++)
      for (int k = 0; k < NK; k++)
        case (mode)
          0: im[r][k] = 16'sh0100;
          1: im[r][k] = W'(k * 256);
          2: im[r][k] = 16'sh7F00;
          3: im[r][k] = (r == 0 && k == 0) ? 16'shFF00 : 16'sh0;
          default: im[r][k] = rnd_el();
        endcase
    for (int k = 0; k < NK; k++)
      for (int j = 0; j < NW; j++)
        case (mode)
          0: wm[k][j] = 16'sh0100;
          1: wm[k][j] = (k == j) ? 16'sh0100 : 16'sh0;
          2: wm[k][j] = 16'sh7F00;
          3: wm[k][j] = (k == 0 && j == 0) ? 16'sh0100 : 16'sh0;
          default: wm[k][j] = rnd_el();
        endcase
  endtask

  task automatic run_job(int freeze, int do_rst);
    int wi, ii, t_last, n, span;
    bit sw, si, frozen;
    exp_t e;
    rdy_cyc.delete();
    for (int r = 0; r < NI; r++) begin
      e.data = model_row(r);
      e.last = (r == NI - 1);
      exp_q.push_back(e);
    end
    en = 1'b1;
    wi = 0;
    ii = 0;
    while (wi < NK || ii < NI) begin
      sw = (wi < NK) && ($urandom_range(0, 3) != 0);
      si = (ii < NI) && ($urandom_range(0, 3) != 0);
      w_valid = sw;
      i_valid = si;
      w_data = sw ? pack_w(wi) : {$urandom, $urandom, $urandom};
      i_data = si ? pack_i(ii)
                  : {$urandom, $urandom, $urandom, $urandom};
      if (wi == NK && $urandom_range(0, 1) == 1) w_valid = 1'b1;
      if (ii == NI && $urandom_range(0, 1) == 1) i_valid = 1'b1;
      @(posedge clk); #1;
      if (sw) wi++;
      if (si) ii++;
    end
    t_last = cyc;
    w_valid = 1'b0;
    i_valid = 1'b0;
    n = 0;
    frozen = 1'b0;
    while (rdy_cyc.size() < NI && n < 300) begin
      @(posedge clk); #1;
      n++;
      if (freeze != 0 && !frozen && rdy_cyc.size() == 2) begin
        en = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        en = 1'b1;
        frozen = 1'b1;
      end
      if (do_rst != 0 && rdy_cyc.size() == 3) begin
        @(posedge clk); #1;
        rst_n = 1'b0;
        en = 1'b0;
        @(posedge clk); #1;
        chk("rst_ready", 128'(o_ready), 128'(0));
        chk("rst_last", 128'(o_last), 128'(0));
        chk("rst_done", 128'(o_done), 128'(0));
        chk("rst_data", 128'(o_data), 128'(0));
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (20) begin @(posedge clk); #1; end
        chk("rst_no_beats", 128'(rdy_cyc.size()), 128'(3));
        return;
      end
    end
    chk("beat_count", 128'(rdy_cyc.size()), 128'(NI));
    if (rdy_cyc.size() == NI) begin
      span = rdy_cyc[NI-1] - rdy_cyc[0];
      chk("first_latency", 128'(rdy_cyc[0] - t_last), 128'(4));
      chk("beat_span", 128'(span), 128'(33 + (freeze != 0 ? 5 : 0)));
    end
    n = 0;
    while (o_done !== 1'b1 && n < 5) begin
      @(posedge clk); #1;
      n++;
    end
    chk("done_set", 128'(o_done), 128'(1));
    chk("sb_empty", 128'(exp_q.size()), 128'(0));
    en = 1'b0;
    @(posedge clk); #1;
    chk("done_clear", 128'(o_done), 128'(0));
  endtask

  initial begin
    rst_n = 1'b0;
    en = 1'b0;
    i_valid = 1'b0;
    w_valid = 1'b0;
    i_data = '0;
    w_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", 128'(o_ready), 128'(0));
    chk("reset_last", 128'(o_last), 128'(0));
    chk("reset_done", 128'(o_done), 128'(0));
    chk("reset_data", 128'(o_data), 128'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int m = 0; m < 4; m++) begin
      fill(m);
      run_job(0, 0);
    end
    for (int t = 0; t < 3; t++) begin
      fill(4);
      run_job(0, 0);
    end
    fill(4);
    run_job(1, 0);
    fill(4);
    run_job(0, 1);
    fill(4);
    run_job(0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
